// File: rtl/menu_dispatch_pkg.sv
// Shared definitions for the front-panel menu dispatcher: FSM states,
// key indices and the sub-module slot count.
package menu_dispatch_pkg;

  localparam int unsigned NUM_SUB_MAX = 8;
  localparam int unsigned NUM_KEYS    = 4;

  localparam int unsigned KEY_NEXT  = 0;
  localparam int unsigned KEY_PREV  = 1;
  localparam int unsigned KEY_ENTER = 2;
  localparam int unsigned KEY_BACK  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [NUM_SUB_MAX-1:0] onehot_sel(input logic [2:0] idx);
    logic [NUM_SUB_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One panel key: 2-FF synchroniser, stability counter and a single-cycle
// pulse on each accepted press (releases are debounced but silent).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned     CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d   = {sync_q[0], key_raw};
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // Counter tracks consecutive cycles of disagreement; any agreement clears it.
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        press_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/menu_dispatch.sv
// Menu controller: debounced cursor navigation over N_SUB slots and the
// initiator side of the en_sub / en_back run handshake.
module menu_dispatch
  import menu_dispatch_pkg::*;
#(
  parameter int unsigned N_SUB           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ABORT_TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] keys,
  input  logic [7:0] en_back,
  output logic [7:0] en_sub,
  output logic [7:0] menu_led,
  output logic       menu_active,
  output logic [2:0] sel
);

  localparam int unsigned   TW       = $clog2(ABORT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ABORT_TIMEOUT);
  localparam logic [2:0]    SEL_LAST = 3'(N_SUB - 1);
  localparam logic [7:0]    SUB_MASK = 8'((1 << N_SUB) - 1);

  logic [NUM_KEYS-1:0] press;
  logic                unused_keys;

  state_e        state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    en_sub_q, en_sub_d;
  logic [7:0]    menu_led_q, menu_led_d;

  assign unused_keys = ^keys[6:4];

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .key_raw(keys[i]),
      .press  (press[i])
    );
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        // Back outranks everything but has no effect while browsing.
        if (press[KEY_BACK]) begin
          state_d = ST_IDLE;
        end else if (press[KEY_ENTER]) begin
          state_d = ST_RUN;
        end else if (press[KEY_NEXT]) begin
          sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        end else if (press[KEY_PREV]) begin
          sel_d = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
        end
      end
      ST_RUN: begin
        if (en_back[sel_q] || press[KEY_BACK]) begin
          state_d = ST_DRAIN;
          tmo_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (!en_back[sel_q] || (tmo_q == TMO_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from next-state so they line up with the state flop.
    en_sub_d   = (state_d == ST_RUN)  ? (onehot_sel(sel_d) & SUB_MASK) : '0;
    menu_led_d = (state_d == ST_IDLE) ? onehot_sel(sel_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      tmo_q      <= '0;
      en_sub_q   <= '0;
      menu_led_q <= 8'h01;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tmo_q      <= tmo_d;
      en_sub_q   <= en_sub_d;
      menu_led_q <= menu_led_d;
    end
  end

  assign en_sub      = en_sub_q;
  assign menu_led    = menu_led_q;
  assign menu_active = (state_q == ST_IDLE);
  assign sel         = sel_q;

endmodule
